truth_table_reader: RTL
=======================

Name: truth_table_reader

Overview:
- Hardware characterizer for 3-input combinational gate models, the read side of the truth-table gate modules.
- Sweeps all 8 input combinations into a gate under test (DUT) and waits a programmable settle time per combination.
- Samples the DUT output and assembles the 8-bit truth-table code, e.g. 0x37.
- Compares the code against an expected code. Used in gate-library regression and self-check wrappers.

Parameters:
- SETTLE_CYCLES, default 4: cycles each combination is held before sampling. Legal range 2..255.
- CNT_W, default 8: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep. Accepted only in IDLE.
- expected  input  8  reference code. Sampled on the start-accept cycle.
- drv_in1  output  1  DUT input in1 (MSB of combination).
- drv_in2  output  1  DUT input in2.
- drv_in3  output  1  DUT input in3 (LSB).
- dut_out  input  1  DUT output.
- busy  output  1  high from the cycle after start-accept through the DONE cycle.
- done  output  1  one-cycle pulse; result outputs valid.
- table_code  output  8  captured code.
- match  output  1  table_code == latched expected. Valid with done.
- unstable  output  1  sticky per sweep: DUT output changed between the last settle cycle and the sample cycle, for any combination.

Behaviour:
- Reset values: all outputs 0, state IDLE, idx=0, cnt=0, latched expected=0.
- Reset has priority over every other event, including mid-sweep. The sweep is abandoned and the DUT inputs are driven to 000 on the next cycle.
- Code mapping: combination idx = {in1,in2,in3}, range 0..7. table_code[7-idx] = DUT output for idx. Bit 7 corresponds to 000 and bit 0 to 111.
  - Example: outputs 0,0,1,1,0,1,1,1 for idx 0..7 give 0x37.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - drv_in = 000.
  - When start=1: latch expected, clear table_code/unstable/match, set idx=0 and cnt=0, then go to DRIVE.
- DRIVE:
  - drv_in = idx, registered, so it changes on entry to DRIVE.
  - cnt increments each cycle. After SETTLE_CYCLES cycles in DRIVE (cnt reaches SETTLE_CYCLES-1), go to SAMPLE.
  - dut_out is registered every cycle as prev_out.
- SAMPLE (1 cycle):
  - drv_in is held.
  - table_code[7-idx] <= dut_out.
  - If dut_out != prev_out, set unstable <= 1.
  - If idx==7, go to DONE. Otherwise idx <= idx+1, cnt <= 0, go to DRIVE.
- DONE (1 cycle):
  - done=1, busy=1.
  - match <= (final table_code == latched expected), visible in the same cycle as done. This is computed combinationally from the final code, then registered.
  - drv_in returns to 000. Next state is IDLE.
- Latency: start accepted at cycle T. Combination k is in DRIVE for cycles T+1+k(S+1) .. T+k(S+1)+S, and in SAMPLE at T+(k+1)(S+1), where S = SETTLE_CYCLES. DONE occurs at T+8(S+1)+1.
  - Default S=4: done at T+41.
- start while busy (DRIVE/SAMPLE/DONE) is ignored. No queuing.
- start in the cycle after DONE (back in IDLE) is accepted normally.
- table_code, match and unstable hold their values after DONE until the next start-accept or reset.
- expected changes after start-accept have no effect on the current sweep.

Test Plan:
- DUT behavioural model of 0x37, S=4, expected=0x37, start pulse at T → drv_in steps 000..111, each held 5 cycles. done at T+41 with table_code=0x37, match=1, unstable=0.
- Same DUT, expected=0x38 → table_code=0x37, match=0. Then a second sweep with a constant-1 DUT → 0xFF. A constant-0 DUT → 0x00.
- DUT that toggles its output exactly on the SAMPLE cycle of idx=5 → unstable=1 at done. table_code bit 2 takes the SAMPLE-cycle value.
- start held high for the whole sweep → exactly one done pulse. A second sweep is accepted in the cycle after done, busy drops for one cycle, then the next done arrives at 8(S+1)+1 after re-accept.
- reset asserted at T+20 mid-sweep → next cycle all outputs 0 and drv_in=000. A new start then gives a full, correct sweep.
- S=2 (minimum) with the 0x37 DUT → done at T+25, table_code=0x37.

Source files
------------

// File: rtl/truth_table_reader.sv
// ============================================================================
// Module      : truth_table_reader
// Description : Sweeps all 8 input combinations into a 3-input gate, samples
//               its output after a settle time and builds the truth-table code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_reader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       drv_in1,
    output logic       drv_in2,
    output logic       drv_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_code,
    output logic       match,
    output logic       unstable
);

    localparam logic [1:0]       c_st_idle   = 2'd0;
    localparam logic [1:0]       c_st_drive  = 2'd1;
    localparam logic [1:0]       c_st_sample = 2'd2;
    localparam logic [1:0]       c_st_done   = 2'd3;
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [2:0]       r_idx;
    logic [2:0]       r_drv;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_expected;
    logic [7:0]       r_code;
    logic [7:0]       w_code_next;
    logic             r_prev_out;
    logic             r_match;
    logic             r_unstable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (start) w_state_next = c_st_drive;
            c_st_drive:  if (r_cnt == c_cnt_last) w_state_next = c_st_sample;
            c_st_sample: w_state_next = (r_idx == 3'd7) ? c_st_done : c_st_drive;
            c_st_done:   w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // Code with the current sample merged in; bit 7 holds combination 000.
    always_comb begin
        w_code_next                = r_code;
        w_code_next[3'd7 - r_idx]  = dut_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= 3'd0;
            r_drv      <= 3'd0;
            r_cnt      <= '0;
            r_expected <= 8'd0;
            r_code     <= 8'd0;
            r_prev_out <= 1'b0;
            r_match    <= 1'b0;
            r_unstable <= 1'b0;
        end else begin
            r_prev_out <= dut_out;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_expected <= expected;
                        r_code     <= 8'd0;
                        r_unstable <= 1'b0;
                        r_match    <= 1'b0;
                        r_idx      <= 3'd0;
                        r_cnt      <= '0;
                        r_drv      <= 3'd0;
                    end
                end
                c_st_drive: begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
                c_st_sample: begin
                    r_code <= w_code_next;
                    if (dut_out != r_prev_out) r_unstable <= 1'b1;
                    // Match is registered here so it appears together with done.
                    if (r_idx == 3'd7) begin
                        r_match <= (w_code_next == r_expected);
                        r_drv   <= 3'd0;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                        r_cnt <= '0;
                        r_drv <= r_idx + 3'd1;
                    end
                end
                default: begin
                    r_drv <= 3'd0;
                end
            endcase
        end
    end

    assign {drv_in1, drv_in2, drv_in3} = r_drv;
    assign busy       = (r_state != c_st_idle);
    assign done       = (r_state == c_st_done);
    assign table_code = r_code;
    assign match      = r_match;
    assign unstable   = r_unstable;

endmodule

`default_nettype wire
